// File: rtl/udma_i2c_evt_pkg.sv
// Shared constants and types for the uDMA I2C event/interrupt controller.
package udma_i2c_evt_pkg;

    localparam int unsigned EVT_RX  = 0;
    localparam int unsigned EVT_TX  = 1;
    localparam int unsigned EVT_CMD = 2;
    localparam int unsigned EVT_ERR = 3;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_TIMEOUT = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_TOTAL   = 2'd3;

    localparam int unsigned CFG_THR_W = 8;
    localparam int unsigned CFG_TO_W  = 16;

    typedef struct packed {
        logic [CFG_TO_W-1:0]  timeout;
        logic [CFG_THR_W-1:0] thr;
        logic                 nack_en;
        logic                 err_en;
        logic [3:0]           mask;
    } ch_cfg_t;

    localparam ch_cfg_t CH_CFG_RST = '{
        timeout: '0,
        thr:     CFG_THR_W'(1),
        nack_en: 1'b0,
        err_en:  1'b0,
        mask:    4'hF
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } coal_state_e;

endpackage

// File: rtl/udma_i2c_evt_coalesce.sv
// Per-channel EOT interrupt coalescing: fires after THR end-of-transfers
// or after TIMEOUT cycles with a batch open, whichever comes first.
module udma_i2c_evt_coalesce
    import udma_i2c_evt_pkg::*;
#(
    parameter int unsigned THR_W = CFG_THR_W,
    parameter int unsigned TO_W  = CFG_TO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eot,
    input  logic [THR_W-1:0] thr,
    input  logic [TO_W-1:0]  timeout,
    output logic             irq,
    output logic             pending,
    output logic [THR_W-1:0] cnt
);

    coal_state_e      state_q, state_d;
    logic [THR_W-1:0] cnt_q, cnt_d;
    logic [THR_W-1:0] thr_eff;
    logic [THR_W:0]   cnt_inc;
    logic [TO_W-1:0]  tmr_q, tmr_d, tmr_inc;
    logic             to_en, to_hit, thr_one;

    assign thr_eff = (thr == '0) ? THR_W'(1) : thr;
    assign thr_one = (thr_eff == THR_W'(1));
    assign to_en   = (timeout != '0);
    assign tmr_inc = tmr_q + 1'b1;
    assign to_hit  = to_en && (tmr_inc == timeout);
    // One extra bit so a count at the top of the range cannot wrap before the compare.
    assign cnt_inc = {1'b0, cnt_q} + {{THR_W{1'b0}}, eot};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            IDLE: begin
                if (eot) begin
                    tmr_d = '0;
                    if (thr_one) begin
                        state_d = FIRE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ACCUM;
                        cnt_d   = THR_W'(1);
                    end
                end
            end
            ACCUM: begin
                cnt_d = cnt_inc[THR_W-1:0];
                tmr_d = to_en ? tmr_inc : tmr_q;
                if ((cnt_inc >= {1'b0, thr_eff}) || to_hit) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            end
            FIRE: begin
                cnt_d = '0;
                tmr_d = '0;
                if (eot) begin
                    if (thr_one) begin
                        state_d = FIRE;
                    end else begin
                        state_d = ACCUM;
                        cnt_d   = THR_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    assign irq     = (state_q == FIRE);
    assign pending = (state_q == ACCUM);
    assign cnt     = cnt_q;

endmodule

// File: rtl/udma_i2c_evt_ctrl.sv
// Multi-channel event/interrupt controller for uDMA I2C instances: masked event
// pass-through, sticky err/nack status, EOT totals and coalesced EOT interrupts.
module udma_i2c_evt_ctrl
    import udma_i2c_evt_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned THR_W = CFG_THR_W,
    parameter int unsigned TO_W  = CFG_TO_W,
    parameter int unsigned TOT_W = 16
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cfg_data_i,
    input  logic [4:0]        cfg_addr_i,
    input  logic              cfg_valid_i,
    input  logic              cfg_rwn_i,
    output logic              cfg_ready_o,
    output logic [31:0]       cfg_data_o,
    input  logic [N_CH*4-1:0] evt_i,
    input  logic [N_CH-1:0]   eot_i,
    input  logic [N_CH-1:0]   nack_i,
    output logic [N_CH*4-1:0] events_o,
    output logic [N_CH-1:0]   irq_eot_o,
    output logic [N_CH-1:0]   irq_err_o
);

    logic [2:0]  acc_ch;
    logic [1:0]  acc_reg;
    logic        wr_en;
    logic [31:0] rd_data [N_CH];
    logic        unused_cfg_bits;

    assign acc_ch          = cfg_addr_i[4:2];
    assign acc_reg         = cfg_addr_i[1:0];
    assign wr_en           = cfg_valid_i & ~cfg_rwn_i;
    assign cfg_ready_o     = 1'b1;
    assign unused_cfg_bits = ^cfg_data_i;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ch_cfg_t          cfg_q;
        logic             err_q, nack_q;
        logic [3:0]       evt_q;
        logic [TOT_W-1:0] total_q;
        logic             wr_hit, w1c, tot_clr;
        logic             pend;
        logic [THR_W-1:0] bcnt;
        logic [31:0]      rdata;

        assign wr_hit  = wr_en && (acc_ch == 3'(c));
        assign w1c     = wr_hit && (acc_reg == REG_STATUS);
        assign tot_clr = wr_hit && (acc_reg == REG_TOTAL);

        always_ff @(posedge sys_clk_i) begin
            if (rst_i) begin
                cfg_q   <= CH_CFG_RST;
                err_q   <= 1'b0;
                nack_q  <= 1'b0;
                evt_q   <= '0;
                total_q <= '0;
            end else begin
                evt_q <= evt_i[c*4 +: 4] & cfg_q.mask;
                if (wr_hit && (acc_reg == REG_CTRL)) begin
                    cfg_q.mask    <= cfg_data_i[3:0];
                    cfg_q.err_en  <= cfg_data_i[4];
                    cfg_q.nack_en <= cfg_data_i[5];
                    cfg_q.thr     <= cfg_data_i[8 +: THR_W];
                end
                if (wr_hit && (acc_reg == REG_TIMEOUT)) begin
                    cfg_q.timeout <= cfg_data_i[TO_W-1:0];
                end
                // A new set in the clearing cycle wins over W1C.
                err_q  <= (err_q  & ~(w1c & cfg_data_i[0])) | evt_i[c*4 + EVT_ERR];
                nack_q <= (nack_q & ~(w1c & cfg_data_i[1])) | nack_i[c];
                if (tot_clr) begin
                    total_q <= eot_i[c] ? TOT_W'(1) : '0;
                end else if (eot_i[c] && (total_q != '1)) begin
                    total_q <= total_q + 1'b1;
                end
            end
        end

        udma_i2c_evt_coalesce #(
            .THR_W (THR_W),
            .TO_W  (TO_W)
        ) u_coalesce (
            .clk     (sys_clk_i),
            .rst     (rst_i),
            .eot     (eot_i[c]),
            .thr     (cfg_q.thr),
            .timeout (cfg_q.timeout),
            .irq     (irq_eot_o[c]),
            .pending (pend),
            .cnt     (bcnt)
        );

        always_comb begin
            rdata = '0;
            unique case (acc_reg)
                REG_CTRL: begin
                    rdata[3:0]        = cfg_q.mask;
                    rdata[4]          = cfg_q.err_en;
                    rdata[5]          = cfg_q.nack_en;
                    rdata[8 +: THR_W] = cfg_q.thr;
                end
                REG_TIMEOUT: rdata[TO_W-1:0] = cfg_q.timeout;
                REG_STATUS: begin
                    rdata[0]          = err_q;
                    rdata[1]          = nack_q;
                    rdata[2]          = pend;
                    rdata[8 +: THR_W] = bcnt;
                end
                default: rdata[TOT_W-1:0] = total_q;
            endcase
        end

        assign rd_data[c]         = rdata;
        assign events_o[c*4 +: 4] = evt_q;
        assign irq_err_o[c]       = (err_q & cfg_q.err_en) | (nack_q & cfg_q.nack_en);
    end

    always_comb begin
        cfg_data_o = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (acc_ch == 3'(i)) begin
                cfg_data_o = rd_data[i];
            end
        end
    end

endmodule

// File: tb/tb_udma_i2c_evt_ctrl.sv
// Directed self-checking bench for udma_i2c_evt_ctrl (N_CH = 2, default widths).
module tb_udma_i2c_evt_ctrl;

    localparam int unsigned N_CH = 2;

    logic              sys_clk_i = 1'b0;
    logic              rst_i     = 1'b1;
    logic [31:0]       cfg_data_i  = '0;
    logic [4:0]        cfg_addr_i  = '0;
    logic              cfg_valid_i = 1'b0;
    logic              cfg_rwn_i   = 1'b0;
    logic              cfg_ready_o;
    logic [31:0]       cfg_data_o;
    logic [N_CH*4-1:0] evt_i  = '0;
    logic [N_CH-1:0]   eot_i  = '0;
    logic [N_CH-1:0]   nack_i = '0;
    logic [N_CH*4-1:0] events_o;
    logic [N_CH-1:0]   irq_eot_o;
    logic [N_CH-1:0]   irq_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk_i = ~sys_clk_i;

    udma_i2c_evt_ctrl #(
        .N_CH  (N_CH),
        .THR_W (8),
        .TO_W  (16),
        .TOT_W (16)
    ) dut (
        .sys_clk_i   (sys_clk_i),
        .rst_i       (rst_i),
        .cfg_data_i  (cfg_data_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_rwn_i   (cfg_rwn_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_data_o  (cfg_data_o),
        .evt_i       (evt_i),
        .eot_i       (eot_i),
        .nack_i      (nack_i),
        .events_o    (events_o),
        .irq_eot_o   (irq_eot_o),
        .irq_err_o   (irq_err_o)
    );

    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        cfg_addr_i  = addr;
        cfg_data_i  = data;
        cfg_rwn_i   = 1'b0;
        cfg_valid_i = 1'b1;
        @(negedge sys_clk_i);
        cfg_valid_i = 1'b0;
        cfg_data_i  = '0;
    endtask

    task automatic cfg_read(input logic [4:0] addr, output logic [31:0] data);
        cfg_addr_i  = addr;
        cfg_rwn_i   = 1'b1;
        cfg_valid_i = 1'b1;
        #1 data = cfg_data_o;
        @(negedge sys_clk_i);
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_i = 1'b1;
        repeat (3) @(negedge sys_clk_i);
        rst_i = 1'b0;
        n_checks++;
        if ({events_o, irq_eot_o, irq_err_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {events_o, irq_eot_o, irq_err_o});
        end
        n_checks++;
        if (cfg_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", cfg_ready_o);
        end
        cfg_read(5'h00, rd);
        n_checks++;
        if (rd !== 32'h0000_010F) begin
            n_fail++; $display("FAIL reset_ctrl0: got %h expected 0000010f", rd);
        end
        cfg_read(5'h04, rd);
        n_checks++;
        if (rd !== 32'h0000_010F) begin
            n_fail++; $display("FAIL reset_ctrl1: got %h expected 0000010f", rd);
        end
        cfg_read(5'h01, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_timeout0: got %h expected 0", rd);
        end
        cfg_read(5'h02, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_status0: got %h expected 0", rd);
        end
        cfg_read(5'h03, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_total0: got %h expected 0", rd);
        end
    endtask

    task automatic test_event_mask();
        logic [31:0] rd;
        evt_i[3:0] = 4'hF;
        @(negedge sys_clk_i);
        evt_i = '0;
        n_checks++;
        if (events_o[3:0] !== 4'hF) begin
            n_fail++; $display("FAIL evt_unmasked: got %h expected f", events_o[3:0]);
        end
        @(negedge sys_clk_i);
        n_checks++;
        if (events_o !== 8'h00) begin
            n_fail++; $display("FAIL evt_one_cycle: got %h expected 00", events_o);
        end
        cfg_write(5'h00, 32'h0000_0105);
        evt_i = 8'h6F;
        @(negedge sys_clk_i);
        evt_i = '0;
        n_checks++;
        if (events_o !== 8'h65) begin
            n_fail++; $display("FAIL evt_masked: got %h expected 65", events_o);
        end
        cfg_read(5'h02, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL evt_err_sticky: got %h expected 1", rd);
        end
        cfg_write(5'h02, 32'h1);
        cfg_read(5'h02, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL evt_err_w1c: got %h expected 0", rd);
        end
        cfg_write(5'h00, 32'h0000_010F);
    endtask

    task automatic test_coalesce_threshold();
        logic [31:0] rd;
        int pulses = 0;
        int first  = -1;
        cfg_write(5'h03, 32'h0);
        cfg_write(5'h00, 32'h0000_030F);
        for (int i = 0; i < 15; i++) begin
            eot_i[0] = (i % 5 == 0);
            @(negedge sys_clk_i);
            if (irq_eot_o[0]) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        eot_i[0] = 1'b0;
        n_checks++;
        if (pulses !== 1 || first !== 10) begin
            n_fail++; $display("FAIL thr3_irq: got %0d pulses first at %0d expected 1 pulse at 10", pulses, first);
        end
        cfg_read(5'h03, rd);
        n_checks++;
        if (rd !== 32'd3) begin
            n_fail++; $display("FAIL thr3_total: got %0d expected 3", rd);
        end
        cfg_read(5'h02, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL thr3_status: got %h expected 0", rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int pulses   = 0;
        int first    = -1;
        int pend_bad = 0;
        cfg_write(5'h00, 32'h0000_040F);
        cfg_write(5'h01, 32'd10);
        cfg_addr_i  = 5'h02;
        cfg_rwn_i   = 1'b1;
        cfg_valid_i = 1'b1;
        eot_i[0]    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk_i);
            eot_i[0] = 1'b0;
            if (irq_eot_o[0]) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i < 10 && cfg_data_o[2] !== 1'b1) pend_bad++;
            if (i >= 10 && cfg_data_o[2] !== 1'b0) pend_bad++;
        end
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b0;
        n_checks++;
        if (pulses !== 1 || first !== 10) begin
            n_fail++; $display("FAIL timeout_irq: got %0d pulses first at %0d expected 1 pulse at 10", pulses, first);
        end
        n_checks++;
        if (pend_bad !== 0) begin
            n_fail++; $display("FAIL timeout_pending: got %0d bad cycles expected 0", pend_bad);
        end
        cfg_read(5'h03, rd);
        n_checks++;
        if (rd !== 32'd4) begin
            n_fail++; $display("FAIL timeout_total: got %0d expected 4", rd);
        end
        cfg_write(5'h01, 32'h0);
    endtask

    task automatic test_thr_edges();
        logic [31:0] rd;
        cfg_write(5'h00, 32'h0000_000F);
        eot_i[0] = 1'b1;
        @(negedge sys_clk_i);
        eot_i[0] = 1'b0;
        n_checks++;
        if (irq_eot_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL thr0_fire: got %b expected 1", irq_eot_o[0]);
        end
        @(negedge sys_clk_i);
        n_checks++;
        if (irq_eot_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL thr0_single: got %b expected 0", irq_eot_o[0]);
        end
        cfg_write(5'h00, 32'h0000_040F);
        eot_i[0] = 1'b1;
        repeat (2) @(negedge sys_clk_i);
        eot_i[0] = 1'b0;
        cfg_read(5'h02, rd);
        n_checks++;
        if (rd !== 32'h0000_0204) begin
            n_fail++; $display("FAIL thr_lower_status: got %h expected 00000204", rd);
        end
        cfg_write(5'h00, 32'h0000_010F);
        n_checks++;
        if (irq_eot_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL thr_lower_early: got %b expected 0", irq_eot_o[0]);
        end
        @(negedge sys_clk_i);
        n_checks++;
        if (irq_eot_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL thr_lower_fire: got %b expected 1", irq_eot_o[0]);
        end
        @(negedge sys_clk_i);
    endtask

    task automatic test_nack_w1c();
        logic [31:0] rd;
        cfg_write(5'h04, 32'h0000_012F);
        nack_i[1] = 1'b1;
        @(negedge sys_clk_i);
        nack_i[1] = 1'b0;
        n_checks++;
        if (irq_err_o[1] !== 1'b1) begin
            n_fail++; $display("FAIL nack_irq: got %b expected 1", irq_err_o[1]);
        end
        cfg_read(5'h06, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL nack_status: got %h expected 2", rd);
        end
        nack_i[1] = 1'b1;
        cfg_write(5'h06, 32'h2);
        nack_i[1] = 1'b0;
        n_checks++;
        if (irq_err_o[1] !== 1'b1) begin
            n_fail++; $display("FAIL nack_race: got %b expected 1", irq_err_o[1]);
        end
        cfg_write(5'h06, 32'h2);
        n_checks++;
        if (irq_err_o[1] !== 1'b0) begin
            n_fail++; $display("FAIL nack_w1c: got %b expected 0", irq_err_o[1]);
        end
        evt_i[7] = 1'b1;
        @(negedge sys_clk_i);
        evt_i[7] = 1'b0;
        n_checks++;
        if (irq_err_o[1] !== 1'b0) begin
            n_fail++; $display("FAIL err_disabled: got %b expected 0", irq_err_o[1]);
        end
        cfg_read(5'h06, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL err_status: got %h expected 1", rd);
        end
        cfg_write(5'h04, 32'h0000_013F);
        n_checks++;
        if (irq_err_o !== 2'b10) begin
            n_fail++; $display("FAIL err_enabled: got %b expected 10", irq_err_o);
        end
        cfg_write(5'h06, 32'h1);
        n_checks++;
        if (irq_err_o[1] !== 1'b0) begin
            n_fail++; $display("FAIL err_w1c: got %b expected 0", irq_err_o[1]);
        end
        cfg_write(5'h04, 32'h0000_010F);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0]  pat;
        pat = '0;
        cfg_write(5'h03, 32'h0);
        cfg_write(5'h00, 32'h0000_020F);
        for (int i = 0; i < 8; i++) begin
            eot_i[0] = (i < 5);
            @(negedge sys_clk_i);
            pat[i] = irq_eot_o[0];
        end
        eot_i[0] = 1'b0;
        n_checks++;
        if (pat !== 8'b0000_1010) begin
            n_fail++; $display("FAIL b2b_irq_pattern: got %b expected 00001010", pat);
        end
        cfg_read(5'h02, rd);
        n_checks++;
        if (rd !== 32'h0000_0104) begin
            n_fail++; $display("FAIL b2b_status: got %h expected 00000104", rd);
        end
        cfg_read(5'h03, rd);
        n_checks++;
        if (rd !== 32'd5) begin
            n_fail++; $display("FAIL b2b_total: got %0d expected 5", rd);
        end
    endtask

    task automatic test_reset_mid_batch();
        logic [31:0] rd;
        int pulses = 0;
        cfg_write(5'h04, 32'h0000_030F);
        eot_i[1] = 1'b1;
        repeat (2) @(negedge sys_clk_i);
        eot_i[1] = 1'b0;
        cfg_read(5'h06, rd);
        n_checks++;
        if (rd !== 32'h0000_0204) begin
            n_fail++; $display("FAIL mid_pending: got %h expected 00000204", rd);
        end
        rst_i = 1'b1;
        @(negedge sys_clk_i);
        rst_i = 1'b0;
        if (irq_eot_o !== 2'b00) pulses++;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk_i);
            if (irq_eot_o !== 2'b00) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL mid_no_irq: got %0d irq cycles expected 0", pulses);
        end
        cfg_read(5'h06, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL mid_status1: got %h expected 0", rd);
        end
        cfg_read(5'h07, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL mid_total1: got %h expected 0", rd);
        end
        cfg_read(5'h04, rd);
        n_checks++;
        if (rd !== 32'h0000_010F) begin
            n_fail++; $display("FAIL mid_ctrl1: got %h expected 0000010f", rd);
        end
        cfg_read(5'h02, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL mid_status0: got %h expected 0", rd);
        end
        cfg_read(5'h1C, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL oob_read: got %h expected 0", rd);
        end
        cfg_write(5'h1C, 32'hFFFF_FFFF);
        cfg_write(5'h1D, 32'hFFFF_FFFF);
        cfg_read(5'h00, rd);
        n_checks++;
        if (rd !== 32'h0000_010F) begin
            n_fail++; $display("FAIL oob_write_ctrl0: got %h expected 0000010f", rd);
        end
        cfg_read(5'h01, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL oob_write_timeout0: got %h expected 0", rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_event_mask();
        test_coalesce_threshold();
        test_timeout();
        test_thr_edges();
        test_nack_w1c();
        test_back_to_back();
        test_reset_mid_batch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
